mcp_controller: RTL and testbench
=================================

// Module: mcp_controller
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM sequencing the shared-memory datapath (single instr/data memory).
//  Decodes op/funct, drives mux selects, write enables and ALU control every cycle; sits inside mips beside datapath.
// PARAMETERS
//  STATE_W    4  width of state register / state_o
//  ALUCTL_W   3  width of alucontrol
// PORTS
//  clk        in   1        rising-edge clock; only clock
//  reset      in   1        synchronous, active-high reset
//  op         in   6        instr[31:26] from IR
//  funct      in   6        instr[5:0] from IR
//  zero       in   1        ALU zero flag
//  pcen       out  1        PC write enable = pcwrite | (branch & zero)
//  memwrite   out  1        memory write strobe
//  irwrite    out  1        instruction register load
//  regwrite   out  1        register file write
//  alusrca    out  1        0=PC, 1=A
//  iord       out  1        mem addr: 0=PC, 1=ALUOut
//  memtoreg   out  1        wb data: 0=ALUOut, 1=Data
//  regdst     out  1        dest: 0=rt, 1=rd
//  immsrc     out  1        0=sign-extend imm, 1=zero-extend imm
//  alusrcb    out  2        00=B, 01=4, 10=imm, 11=imm<<2
//  pcsrc      out  2        00=ALUResult, 01=ALUOut, 10=jump target
//  alucontrol out  3        010 add, 110 sub, 000 and, 001 or, 111 slt
//  state_o    out  STATE_W  current state (observability)
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 RTYPEEX6 RTYPEWB7 BEQEX8 ADDIEX9 IMMWB10 JEX11 ORIEX12 ANDIEX13.
//  Reset: at edge with reset=1 state<=FETCH. While reset=1, all enables (pcen,memwrite,irwrite,regwrite) forced 0, same cycle.
//  Outputs are pure decode of state (plus zero for pcen); unlisted outputs 0.
//  FETCH: iord0 alusrca0 alusrcb01 add pcsrc00 irwrite1 pcwrite1 -> DECODE.
//  DECODE: alusrca0 alusrcb11 add (branch target precompute); next by op:
//   100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, other->FETCH (no writes).
//  MEMADR: alusrca1 alusrcb10 add; lw->MEMRD, sw->MEMWR.  MEMRD: iord1 -> MEMWB.  MEMWB: regdst0 memtoreg1 regwrite1 -> FETCH.
//  MEMWR: iord1 memwrite1 -> FETCH.  RTYPEEX: alusrca1 alusrcb00 ALU from funct -> RTYPEWB.  RTYPEWB: regdst1 memtoreg0 regwrite1 -> FETCH.
//  funct: 100000 add,100010 sub,100100 and,100101 or,101010 slt; other -> 010 (add), no trap.
//  BEQEX: alusrca1 alusrcb00 sub pcsrc01 branch1 -> FETCH.  ADDIEX: alusrca1 alusrcb10 add -> IMMWB.
//  IMMWB: regdst0 memtoreg0 regwrite1 -> FETCH.  JEX: pcsrc10 pcwrite1 -> FETCH.
//  Latency (cycles): lw 5, sw 4, R 4, addi 4, beq 3, j 3. op/funct sampled from IR, stable after FETCH.
//  Reset mid-instruction: aborts; next state FETCH, no partial write issued after reset edge.
// CONFIGURATION
//  MCP_LOGIC_IMM_EN defined: DECODE op 001101->ORIEX, 001100->ANDIEX; both alusrca1 alusrcb10 immsrc1 (or/and) -> IMMWB.
//  Undefined: those opcodes -> FETCH as illegal; immsrc tied 0; states 12,13 unreachable.
// STRUCTURE
//  mcp_pkg: state localparams, opcode/funct constants, ALU control codes, alusrcb/pcsrc encodings.
//  Sub-module mcp_aludec: aluop(2)+funct -> alucontrol, combinational. FSM and output decode in mcp_controller.
// TESTING
//  reset 1 cycle mid-MEMWR -> memwrite 0 during reset, state_o=0 after edge, then irwrite=1.
//  op=100011 -> state_o 0,1,2,3,4,0; MEMRD iord=1; MEMWB regwrite=1 memtoreg=1.
//  op=000000 funct 100010/101010/100101 -> RTYPEEX alucontrol 110/111/001; RTYPEWB regdst=1.
//  op=000100 zero=1 -> BEQEX pcen=1 pcsrc=01; zero=0 -> pcen=0; back to FETCH.
//  op=101011 -> MEMWR memwrite=1 iord=1 in cycle 4; op=111111 -> DECODE->FETCH, no enables.
//  MCP_LOGIC_IMM_EN: op=001101 -> ORIEX immsrc=1 alucontrol=001, IMMWB regwrite=1; undefined -> illegal path.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Covers states, opcodes, funct codes, ALU control and mux select codes.
package mcp_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12,
        S_ANDIEX  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mcp_aludec.sv
// ALU decoder: maps aluop and funct to the ALU control code.
// Unknown funct values fall back to add rather than trapping.
module mcp_aludec
    import mcp_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            AOP_ADD: alucontrol = ALU_ADD;
            AOP_SUB: alucontrol = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcp_controller.sv
// Multicycle MIPS Moore control FSM; define MCP_LOGIC_IMM_EN to add
// the ori/andi execute states (otherwise those opcodes are illegal).
module mcp_controller
    import mcp_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                pcen,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regwrite,
    output logic                alusrca,
    output logic                iord,
    output logic                memtoreg,
    output logic                regdst,
    output logic                immsrc,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic [STATE_W-1:0]  state_o
);

    state_t     state;
    logic       pcwrite;
    logic       branch;
    logic       mw_d;
    logic       irw_d;
    logic       rw_d;
    logic       alu_on;
    logic [1:0] aluop;
    logic [5:0] dfunct;
    logic [2:0] aluc;
`ifdef MCP_LOGIC_IMM_EN
    logic       imm_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_RTYPEEX;
                        OP_BEQ:       state <= S_BEQEX;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JEX;
`ifdef MCP_LOGIC_IMM_EN
                        OP_ORI:       state <= S_ORIEX;
                        OP_ANDI:      state <= S_ANDIEX;
`endif
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:
                    state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   state <= S_MEMWB;
                S_RTYPEEX: state <= S_RTYPEWB;
                S_ADDIEX:  state <= S_IMMWB;
`ifdef MCP_LOGIC_IMM_EN
                S_ORIEX:   state <= S_IMMWB;
                S_ANDIEX:  state <= S_IMMWB;
`endif
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        mw_d     = 1'b0;
        irw_d    = 1'b0;
        rw_d     = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = SRCB_B;
        pcsrc    = PC_ALU;
        alu_on   = 1'b0;
        aluop    = AOP_ADD;
        dfunct   = funct;
`ifdef MCP_LOGIC_IMM_EN
        imm_d    = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                alusrcb = SRCB_4;
                alu_on  = 1'b1;
                irw_d   = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                alu_on  = 1'b1;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_on  = 1'b1;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                rw_d     = 1'b1;
            end
            S_MEMWR: begin
                iord = 1'b1;
                mw_d = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                alu_on  = 1'b1;
                aluop   = AOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst = 1'b1;
                rw_d   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                alu_on  = 1'b1;
                aluop   = AOP_SUB;
                pcsrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_on  = 1'b1;
            end
            S_IMMWB: rw_d = 1'b1;
            S_JEX: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
`ifdef MCP_LOGIC_IMM_EN
            // Reuse the funct path by substituting the wanted funct.
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_on  = 1'b1;
                aluop   = AOP_FUNCT;
                dfunct  = F_OR;
                imm_d   = 1'b1;
            end
            S_ANDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_on  = 1'b1;
                aluop   = AOP_FUNCT;
                dfunct  = F_AND;
                imm_d   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    mcp_aludec u_aludec (
        .aluop      (aluop),
        .funct      (dfunct),
        .alucontrol (aluc)
    );

    assign alucontrol = alu_on ? ALUCTL_W'(aluc) : '0;

    // Enables are masked combinationally so reset kills them immediately.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign memwrite = ~reset & mw_d;
    assign irwrite  = ~reset & irw_d;
    assign regwrite = ~reset & rw_d;

`ifdef MCP_LOGIC_IMM_EN
    assign immsrc = imm_d;
`else
    assign immsrc = 1'b0;
`endif

    assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_mcp_controller.sv
// Self-checking bench for mcp_controller against a per-instruction
// state-sequence model and a per-state output table.
module tb_mcp_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       immsrc;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    int vecs = 0;
    int errs = 0;
    int seq[$];

    mcp_controller #(
        .STATE_W  (4),
        .ALUCTL_W (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .immsrc     (immsrc),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,
    //  immsrc,alusrcb,pcsrc,alucontrol}
    function automatic logic [15:0] exp_out(input int st,
                                            input logic [5:0] fn,
                                            input logic z,
                                            input logic rst);
        logic [15:0] v;
        v = 16'h0;
        case (st)
            0:  v = {4'b1010, 5'b00000, 2'b01, 2'b00, 3'b010};
            1:  v = {4'b0000, 5'b00000, 2'b11, 2'b00, 3'b010};
            2:  v = {4'b0000, 5'b10000, 2'b10, 2'b00, 3'b010};
            3:  v = {4'b0000, 5'b01000, 2'b00, 2'b00, 3'b000};
            4:  v = {4'b0001, 5'b00100, 2'b00, 2'b00, 3'b000};
            5:  v = {4'b0100, 5'b01000, 2'b00, 2'b00, 3'b000};
            6:  v = {4'b0000, 5'b10000, 2'b00, 2'b00, r_alu(fn)};
            7:  v = {4'b0001, 5'b00010, 2'b00, 2'b00, 3'b000};
            8:  v = {z, 3'b000, 5'b10000, 2'b00, 2'b01, 3'b110};
            9:  v = {4'b0000, 5'b10000, 2'b10, 2'b00, 3'b010};
            10: v = {4'b0001, 5'b00000, 2'b00, 2'b00, 3'b000};
            11: v = {4'b1000, 5'b00000, 2'b00, 2'b10, 3'b000};
            12: v = {4'b0000, 5'b10001, 2'b10, 2'b00, 3'b001};
            13: v = {4'b0000, 5'b10001, 2'b10, 2'b00, 3'b000};
            default: v = 16'h0;
        endcase
        if (rst) v[15:12] = 4'b0000;
        return v;
    endfunction

    task automatic build_seq(input logic [5:0] o);
        seq = {0, 1};
        case (o)
            6'b100011: seq = {0, 1, 2, 3, 4};
            6'b101011: seq = {0, 1, 2, 5};
            6'b000000: seq = {0, 1, 6, 7};
            6'b000100: seq = {0, 1, 8};
            6'b001000: seq = {0, 1, 9, 10};
            6'b000010: seq = {0, 1, 11};
`ifdef MCP_LOGIC_IMM_EN
            6'b001101: seq = {0, 1, 12, 10};
            6'b001100: seq = {0, 1, 13, 10};
`endif
            default:   seq = {0, 1};
        endcase
    endtask

    task automatic check(input int st, input string tag);
        logic [15:0] obs;
        logic [15:0] ex;
        logic [3:0]  sx;
        sx  = 4'(st);
        ex  = exp_out(st, funct, zero, reset);
        obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, immsrc, alusrcb, pcsrc, alucontrol};
        vecs++;
        assert (state_o === sx) else begin
            errs++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state_o, sx);
        end
        vecs++;
        assert (obs === ex) else begin
            errs++;
            $error("FAIL %s st%0d outs obs=%b exp=%b", tag, st, obs, ex);
        end
    endtask

    // Starts in FETCH just after a negedge; returns in the next FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] fn,
                             input int zmode, input string tag);
        op    = o;
        funct = fn;
        build_seq(o);
        foreach (seq[i]) begin
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check(seq[i], tag);
            @(negedge clk);
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [9];
        tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b001101, 6'b001100, 6'b111111};
        if ($urandom_range(0, 9) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 8)];
    endfunction

    function automatic logic [5:0] pick_fn();
        logic [5:0] tbl [5];
        tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if ($urandom_range(0, 5) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 4)];
    endfunction

    initial begin
        reset = 1'b1;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(0, "reset_hold");
        reset = 1'b0;

        run_instr(6'b100011, 6'b000000, 0, "lw");
        run_instr(6'b000000, 6'b100010, 0, "r_sub");
        run_instr(6'b000000, 6'b101010, 0, "r_slt");
        run_instr(6'b000000, 6'b100101, 0, "r_or");
        run_instr(6'b000000, 6'b110011, 0, "r_bad");
        run_instr(6'b000100, 6'b000000, 1, "beq_t");
        run_instr(6'b000100, 6'b000000, 0, "beq_nt");
        run_instr(6'b101011, 6'b000000, 2, "sw");
        run_instr(6'b111111, 6'b000000, 2, "illegal");
        run_instr(6'b001000, 6'b000000, 2, "addi");
        run_instr(6'b000010, 6'b000000, 2, "j");
        run_instr(6'b001101, 6'b000000, 2, "ori");
        run_instr(6'b001100, 6'b000000, 2, "andi");

        op = 6'b101011;
        for (int s = 0; s < 3; s++) begin
            #1;
            check(s, "sw_pre");
            @(negedge clk);
        end
        #1;
        check(5, "sw_wr");
        reset = 1'b1;
        #1;
        check(5, "rst_memwr");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check(0, "rst_after");
        @(negedge clk);
        #1;
        check(1, "rst_decode");
        @(negedge clk);
        #1;
        check(2, "rst_resume");
        @(negedge clk);
        #1;
        check(5, "rst_resume_wr");
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            run_instr(pick_op(), pick_fn(), 2, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
